// File: rtl/mnist_pkg.sv
// Shared constants and types for the MNIST network blocks.
package mnist_pkg;

  localparam int IMG_W   = 28;
  localparam int IMG_H   = 28;
  localparam int K       = 3;
  localparam int OUT_CNT = (IMG_W - K + 1) * (IMG_H - K + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    STREAM,
    DRAIN,
    DONE
  } conv1_seq_state_t;

endpackage

// File: rtl/conv1_frame_buf.sv
// Single-bit frame store with one synchronous write port and one registered read port.
// Read data returns to 0 whenever no read is requested, so it can drive the pixel bus directly.
module conv1_frame_buf #(
  parameter int DEPTH = 784,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic          wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic          rdata_o
);

  logic mem_q [DEPTH];
  logic rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)    rdata_q <= 1'b0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
    else           rdata_q <= 1'b0;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/conv1_seq.sv
// Frame sequencer for conv_layer_1: capture a frame, flush the conv pipeline, stream it, count outputs.
// Define CONV1_SEQ_TIMEOUT_EN to build the DRAIN watchdog (abort after TIMEOUT cycles with error).
module conv1_seq #(
  parameter int IMG_W     = mnist_pkg::IMG_W,
  parameter int IMG_H     = mnist_pkg::IMG_H,
  parameter int K         = mnist_pkg::K,
  parameter int OUT_CNT   = (IMG_W - K + 1) * (IMG_H - K + 1),
  parameter int FLUSH_CYC = 2,
  parameter int TIMEOUT   = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       load_valid,
  input  logic       load_pixel,
  output logic       load_ready,
  output logic       conv_rst_n,
  output logic       conv_pixel,
  input  logic       conv_valid,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [9:0] out_count
);

  import mnist_pkg::*;

  localparam int NPIX = IMG_W * IMG_H;
  localparam int PW   = $clog2(NPIX);
  localparam int FW   = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  localparam logic [PW-1:0] LAST_PIX = PW'(NPIX - 1);
  localparam logic [FW-1:0] FLUSH_LD = FW'(FLUSH_CYC - 1);
  localparam logic [9:0]    OUT_EXP  = 10'(OUT_CNT);
  localparam logic [9:0]    CNT_MAX  = 10'h3FF;

  conv1_seq_state_t state_q, state_d;
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [FW-1:0]    flush_q, flush_d;
  logic [9:0]       out_count_q, out_count_d;
  logic             error_q, error_d;
  logic             load_ready_q, conv_rst_n_q, busy_q, done_q;
  logic             accept, cnt_en, rd_en, tmr_exp;
  logic [PW-1:0]    rd_addr;

  assign accept = load_valid && load_ready_q;

`ifdef CONV1_SEQ_TIMEOUT_EN
  localparam int             TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]  TMR_LD = TW'(TIMEOUT - 1);
  logic [TW-1:0] tmr_q, tmr_d;

  // Reloaded throughout STREAM so DRAIN always starts from a full budget.
  always_comb begin
    tmr_d = tmr_q;
    if (state_q == STREAM)     tmr_d = TMR_LD;
    else if (state_q == DRAIN) tmr_d = tmr_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) tmr_q <= '0;
    else        tmr_q <= tmr_d;
  end

  assign tmr_exp = (state_q == DRAIN) && (tmr_q == '0);
`else
  if (TIMEOUT < 1) begin : g_timeout_invalid
  end
  assign tmr_exp = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    flush_d     = flush_q;
    out_count_d = out_count_q;
    error_d     = error_q;
    rd_en       = 1'b0;
    rd_addr     = '0;
    cnt_en      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = LOAD;
          wptr_d      = '0;
          out_count_d = '0;
          error_d     = 1'b0;
        end
      end
      LOAD: begin
        if (accept) begin
          wptr_d = wptr_q + 1'b1;
          if (wptr_q == LAST_PIX) begin
            state_d = FLUSH;
            flush_d = FLUSH_LD;
          end
        end
      end
      FLUSH: begin
        flush_d = flush_q - 1'b1;
        // Last flush cycle issues the read of pixel 0 to hide the buffer read latency.
        if (flush_q == '0) begin
          state_d = STREAM;
          rptr_d  = '0;
          rd_en   = 1'b1;
        end
      end
      STREAM: begin
        rptr_d = rptr_q + 1'b1;
        if (rptr_q == LAST_PIX) begin
          state_d = DRAIN;
        end else begin
          rd_en   = 1'b1;
          rd_addr = rptr_q + 1'b1;
        end
      end
      DRAIN: begin
        if ((out_count_q >= OUT_EXP) || tmr_exp) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    cnt_en = conv_valid && ((state_q == STREAM) || (state_q == DRAIN)) && (out_count_q != CNT_MAX);
    if (cnt_en) begin
      out_count_d = out_count_q + 1'b1;
      if (out_count_q >= OUT_EXP) error_d = 1'b1;
    end
    if ((state_d == DONE) && (out_count_d != OUT_EXP)) error_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wptr_q       <= '0;
      rptr_q       <= '0;
      flush_q      <= '0;
      out_count_q  <= '0;
      error_q      <= 1'b0;
      load_ready_q <= 1'b0;
      conv_rst_n_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      flush_q      <= flush_d;
      out_count_q  <= out_count_d;
      error_q      <= error_d;
      load_ready_q <= (state_d == LOAD);
      conv_rst_n_q <= (state_d != FLUSH);
      busy_q       <= (state_d != IDLE);
      done_q       <= (state_d == DONE);
    end
  end

  conv1_frame_buf #(
    .DEPTH (NPIX),
    .AW    (PW)
  ) u_frame_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (accept),
    .waddr_i (wptr_q),
    .wdata_i (load_pixel),
    .re_i    (rd_en),
    .raddr_i (rd_addr),
    .rdata_o (conv_pixel)
  );

  assign load_ready = load_ready_q;
  assign conv_rst_n = conv_rst_n_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign out_count  = out_count_q;

endmodule

// File: tb/tb_conv1_seq.sv
// Self-checking bench for conv1_seq: random frames and stalls against a cycle-level reference model,
// with a stub standing in for conv_layer_1.
module tb_conv1_seq;

  localparam int IMG_W   = 28;
  localparam int NPIX    = 784;
  localparam int OUT_CNT = 676;

  logic       clk = 1'b0;
  logic       rst_n, start, load_valid, load_pixel;
  logic       conv_valid = 1'b0;
  logic       load_ready, conv_rst_n, conv_pixel, busy, done, error;
  logic [9:0] out_count;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  int  smode = 0;
  int  sn    = 0;
  int  pc    = 0;
  bit  prev_r = 1'b0;
  bit  noise  = 1'b0;
  int  vq [$];
  bit  pix [NPIX];

  conv1_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .load_valid (load_valid),
    .load_pixel (load_pixel),
    .load_ready (load_ready),
    .conv_rst_n (conv_rst_n),
    .conv_pixel (conv_pixel),
    .conv_valid (conv_valid),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .out_count  (out_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stub conv: pc = pixels consumed since conv reset released; a valid for pixel p arrives one cycle later.
  // Mode 0 mimics a 3x3 valid window (676 pulses), mode 1 emits sn back-to-back pulses.
  always @(negedge clk) begin
    if (!prev_r) pc = 0;
    else         pc = pc + 1;
    prev_r = conv_rst_n;
    if (noise)
      conv_valid = 1'($urandom);
    else if (smode == 0)
      conv_valid = (pc >= 1) && (pc <= NPIX) && (((pc - 1) / IMG_W) >= 2) && (((pc - 1) % IMG_W) >= 2);
    else
      conv_valid = (pc >= 1) && (pc <= sn);
    if (conv_valid) vq.push_back(cyc);
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // exp_done: cycle of done relative to the first FLUSH cycle.
  task automatic run_frame(input int stall, input bit rnd, input int mode, input int n,
                           input int exp_done, input int mid_start, input int rst_at);
    int acc, t0, lf, tdone, perr, nv;
    bit seen_done;
    for (int i = 0; i < NPIX; i++)
      pix[i] = rnd ? 1'($urandom) : 1'(((i / IMG_W) + (i % IMG_W)) % 2);
    smode = mode;
    sn    = n;
    noise = 1'b1;
    vq.delete();

    chk("idle_busy", busy, 0);
    start      = 1'b1;
    load_valid = 1'b1;
    load_pixel = ~pix[0];
    tick();
    start = 1'b0;
    chk("start_ready", load_ready, 1);
    chk("start_busy", busy, 1);
    chk("start_cnt_clr", out_count, 0);
    chk("start_err_clr", error, 0);

    acc = 0;
    t0  = cyc;
    while (acc < NPIX && cyc - t0 < 4 * NPIX) begin
      case (stall)
        1:       load_valid = ((cyc % 3) != 0);
        2:       load_valid = 1'($urandom);
        default: load_valid = 1'b1;
      endcase
      load_pixel = pix[acc];
      if (load_valid && load_ready) acc++;
      tick();
    end
    load_valid = 1'b0;
    lf = cyc;
    chk("accepts", acc, NPIX);
    chk("ready_drop", load_ready, 0);
    chk("flush0_rst", conv_rst_n, 0);
    chk("flush_pix", conv_pixel, 0);
    tick();
    chk("flush1_rst", conv_rst_n, 0);
    tick();
    noise = 1'b0;
    chk("stream_rst", conv_rst_n, 1);

    perr = 0;
    for (int k = 0; k < NPIX; k++) begin
      if (conv_pixel !== pix[k]) perr++;
      start = (k == mid_start);
      if (k == rst_at) begin
        start = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("pre_rst_pix", perr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_conv_rst", conv_rst_n, 0);
        chk("rst_pix", conv_pixel, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", load_ready, 0);
        chk("rst_cnt", out_count, 0);
        seen_done = 1'b0;
        for (int j = 0; j < 20; j++) begin
          tick();
          if (done) seen_done = 1'b1;
        end
        chk("rst_no_done", seen_done, 0);
        chk("rst_idle_busy", busy, 0);
        return;
      end
      tick();
    end
    start = 1'b0;
    chk("stream_pix", perr, 0);
    chk("drain_pix", conv_pixel, 0);
    chk("drain_busy", busy, 1);

    while (!done && cyc - lf < 2200) tick();
    tdone = cyc;
    chk("done_cyc", tdone - lf, exp_done);
    nv = 0;
    foreach (vq[i]) if (vq[i] >= lf + 2 && vq[i] < tdone) nv++;
    if (nv > 1023) nv = 1023;
    chk("out_count", out_count, nv);
    chk("error", error, int'(nv != OUT_CNT));
    tick();
    chk("done_pulse", done, 0);
    chk("busy_end", busy, 0);
    chk("error_hold", error, int'(nv != OUT_CNT));
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    load_valid = 1'b0;
    load_pixel = 1'b0;
    repeat (3) tick();
    chk("rst_load_ready", load_ready, 0);
    chk("rst_conv_rst_n", conv_rst_n, 0);
    chk("rst_conv_pixel", conv_pixel, 0);
    chk("rst_busy0", busy, 0);
    chk("rst_done0", done, 0);
    chk("rst_error0", error, 0);
    chk("rst_out_count", out_count, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_conv_rst", conv_rst_n, 1);
    chk("idle_ready", load_ready, 0);

    // Stream window starts 2 cycles after the first FLUSH cycle and lasts 784 cycles.
    run_frame(0, 1'b0, 0, 0,   788, -1,  -1);
    run_frame(1, 1'b1, 0, 0,   788, 100, -1);
    run_frame(2, 1'b1, 1, 680, 787, -1,  -1);
    run_frame(0, 1'b1, 0, 0,   788, -1,  400);
    run_frame(1, 1'b1, 0, 0,   788, -1,  -1);
`ifdef CONV1_SEQ_TIMEOUT_EN
    run_frame(0, 1'b1, 1, 600, 786 + 1024, -1, -1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/conv1_seq.md
# conv1_seq

Frame sequencer for `conv_layer_1`. It captures one 28×28 binary image from an upstream serial loader into a local frame buffer. It then clears the convolution pipeline with a reset flush and streams the frame into `conv_layer_1` at one pixel per cycle, with no gaps. It counts the `valid_out_conv1` pulses that come back and reports frame completion or error to the top-level network controller.

## Interface
Parameters:
- `IMG_W`, 28: image width in pixels.
- `IMG_H`, 28: image height in pixels.
- `K`, 3: convolution kernel size.
- `OUT_CNT`, (IMG_W-K+1)*(IMG_H-K+1) = 676: expected conv1 outputs per frame.
- `FLUSH_CYC`, 2: number of cycles `conv_rst_n` is held low before streaming.
- `TIMEOUT`, 1024: maximum DRAIN cycles (used only with the timeout macro).

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `start`, in, 1: begin a frame. Sampled only in IDLE.
- `load_valid`, in, 1: upstream pixel valid.
- `load_pixel`, in, 1: upstream binary pixel, raster order.
- `load_ready`, out, 1: a pixel is accepted on `load_valid && load_ready`.
- `conv_rst_n`, out, 1: drives the `rst_n` input of `conv_layer_1`.
- `conv_pixel`, out, 1: drives the `pixel_in` input of `conv_layer_1`.
- `conv_valid`, in, 1: driven by `valid_out_conv1`.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse at end of frame.
- `error`, out, 1: valid together with `done`. Holds until the next `start`.
- `out_count`, out, 10: number of conv outputs counted in the current frame.

## Operation
- FSM states: IDLE, LOAD, FLUSH, STREAM, DRAIN, DONE.
- IDLE:
  - `load_ready`=0.
  - `start`=1 → LOAD. This also clears `out_count`, `error`, and the write pointer.
- LOAD:
  - `load_ready`=1.
  - Each accepted pixel is written to `buf[wptr]` and `wptr` increments.
  - The accept at `wptr`==783 → FLUSH. `load_ready` drops in the same cycle the transition takes effect.
- FLUSH:
  - `conv_rst_n`=0 for exactly `FLUSH_CYC` cycles, then → STREAM.
- STREAM:
  - `conv_rst_n`=1.
  - `conv_pixel`=`buf[k]` during the k-th STREAM cycle, k=0..783.
  - After 784 cycles → DRAIN.
- DRAIN:
  - Waits until `out_count`==`OUT_CNT`, then → DONE.
- DONE:
  - `done`=1 for one cycle, then → IDLE.
  - `error`=1 if `out_count`≠`OUT_CNT`.
- Output counting:
  - `out_count` increments on `conv_valid` in STREAM and DRAIN only. It saturates at 1023.
  - `conv_valid` is ignored in IDLE, LOAD, and FLUSH.
  - An increment that makes `out_count` > `OUT_CNT` sets `error` (overrun).
- `conv_pixel`=0 outside STREAM.
- `conv_rst_n`=0 in reset and in FLUSH, and 1 otherwise.
- `start` outside IDLE is ignored.
- In IDLE, `start` and `load_valid` arriving together: no pixel is accepted that cycle.
- Buffer contents are not reset. They are fully overwritten on every frame.

## Timing
- All outputs are registered.
- Reset values:
  - `load_ready`=0, `conv_rst_n`=0, `conv_pixel`=0, `busy`=0, `done`=0, `error`=0, `out_count`=0.
  - FSM resets to IDLE.
- `start` at edge n → `load_ready`=1 and `busy`=1 from cycle n+1.
- Last LOAD accept at edge m:
  - `conv_rst_n`=0 for cycles m+1..m+2.
  - First streamed pixel (`buf[0]`) at cycle m+3.
  - Last streamed pixel (`buf[783]`) at m+786.
- Minimum frame length: 1 (start) + 784 (load) + 2 (flush) + 784 (stream) + DRAIN + 1 (done) cycles.
- `done` is asserted the cycle after DRAIN exits. `busy` is low the cycle after `done`.
- Reset mid-operation (`rst_n`=0 at any edge):
  - Next cycle the FSM is in IDLE and all outputs hold their reset values.
  - `conv_rst_n` is forced low, so `conv_layer_1` is reset as well.
  - The partial frame is discarded and no `done` is issued.
- Upstream stalls (`load_valid`=0) in LOAD simply extend LOAD. No timeout applies in LOAD.

## Configuration
- Macro: `CONV1_SEQ_TIMEOUT_EN`.
- Defined:
  - A DRAIN cycle counter aborts DRAIN after `TIMEOUT` cycles → DONE with `error`=1.
  - `out_count` holds the partial value.
- Undefined:
  - DRAIN waits indefinitely for `OUT_CNT` outputs.
  - No timeout counter is synthesized.

## Structure
- Shared package `mnist_pkg` holds:
  - the `IMG_W`, `IMG_H`, `K`, `OUT_CNT` constants;
  - the `conv1_seq_state_t` enum (IDLE, LOAD, FLUSH, STREAM, DRAIN, DONE).
- One sub-module, `conv1_frame_buf`: a 784×1 memory with one synchronous write port and one synchronous read port. Its 1-cycle read latency is absorbed by prefetching `buf[0]` during the last FLUSH cycle.
- The FSM, pointers, and counters live in the `conv1_seq` top.

## Test plan
- Checkerboard frame (pixel=(i+j)%2) loaded with no stalls, driving a real `conv_layer_1` → expect:
  - `conv_pixel` sequence equals the loaded sequence;
  - 676 `conv_valid` pulses;
  - `done`=1 with `error`=0 and `out_count`=676.
- Load with `load_valid` deasserted every third cycle → expect:
  - exactly 784 accepts;
  - `conv_rst_n` low for exactly 2 cycles;
  - STREAM starts 3 cycles after the last accept.
- Stub conv that returns only 600 valids, with `CONV1_SEQ_TIMEOUT_EN` defined → expect `done` 1024 cycles after DRAIN entry, with `error`=1 and `out_count`=600.
- Stub conv that returns 680 valids → expect `error`=1 at `done`, and `out_count`=680.
- Assert `rst_n`=0 for 1 cycle at STREAM pixel 400 → expect:
  - next cycle: IDLE, `busy`=0, `conv_rst_n`=0, `conv_pixel`=0, and no `done`;
  - a following `start` runs a clean frame.
- `start` pulsed during STREAM, and `start` together with `load_valid` in IDLE → expect the mid-frame `start` to be ignored, and the first pixel to be accepted only in the cycle after `start`.
